sprite_ram_arbiter: RTL

Shares the single-port 128x8 sprite attribute RAM between the sprite engine (read-only, latency-critical) and the CPU bus (read/write). CPU writes are posted into a small write FIFO and drained into RAM in slots the engine leaves unused. CPU reads are ordered behind all posted writes. The block sits between the CPU address decoder, the sprite engine's `spriteram_addr`/`spriteram_data_out` path and the RAM macro.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_wr_fifo.sv | 67 ++++++
 rtl/sprite_ram_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite RAM definitions: geometry, issue-op codes and the
// CPU read FSM state codes used by the arbiter and its write FIFO.
package sprite_pkg;

    localparam int SPR_RAM_ADDR_W     = 7;
    localparam int SPR_RAM_ITEM_WIDTH = 4;
    localparam int SPR_INDEX_MAX      = 15;

    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_ENG    = 2'd1,
        OP_CPU_RD = 2'd2,
        OP_WR     = 2'd3
    } issue_op_e;

    localparam logic [1:0] CR_IDLE  = 2'd0;
    localparam logic [1:0] CR_DRAIN = 2'd1;
    localparam logic [1:0] CR_ISSUE = 2'd2;
    localparam logic [1:0] CR_DATA  = 2'd3;

endpackage

// File: rtl/sprite_wr_fifo.sv
// Posted-write FIFO, first-word-fall-through.
// Ports: push/din in, pop in, dout/full/empty/count out; sync reset.
module sprite_wr_fifo
    import sprite_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Full/empty are judged on the start-of-cycle state, so a push
    // into a full FIFO is refused even if a pop happens alongside.
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Shares the single-port sprite RAM between the sprite engine (reads)
// and the CPU (posted writes, reads ordered behind them).
// Ports: eng_* engine read, cpu_* CPU bus, ram_* registered RAM stage.
module sprite_ram_arbiter
    import sprite_pkg::*;
#(
    parameter int ADDR_W       = SPR_RAM_ADDR_W,
    parameter int DATA_W       = 8,
    parameter int WFIFO_DEPTH  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eng_req,
    input  logic [ADDR_W-1:0] eng_addr,
    output logic              eng_valid,
    output logic [DATA_W-1:0] eng_data,
    input  logic              cpu_cs,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_rd_valid,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int FW = ADDR_W + DATA_W;
    localparam int CW = $clog2(WFIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [FW-1:0]     fifo_dout;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CW-1:0]     fifo_count;
    logic [ADDR_W-1:0] wf_addr;
    logic [DATA_W-1:0] wf_data;
    logic              forced;
    issue_op_e         op, op_q;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [1:0]        cr_q, cr_d;
    logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              eng_valid_q, eng_valid_d;
    logic              rd_ret_q, rd_ret_d;

    assign fifo_push = cpu_cs & cpu_wr & ~fifo_full;
    assign fifo_pop  = (op == OP_WR);
    assign wf_addr   = fifo_dout[FW-1:DATA_W];
    assign wf_data   = fifo_dout[DATA_W-1:0];

    sprite_wr_fifo #(
        .WIDTH (FW),
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({cpu_addr, cpu_din}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A starved FIFO pre-empts even the engine; that engine slot is lost.
    assign forced = (starve_q == STARVE_MAX) & ~fifo_empty;

    always_comb begin
        op = OP_NONE;
        if (forced)                op = OP_WR;
        else if (eng_req)          op = OP_ENG;
        else if (cr_q == CR_ISSUE) op = OP_CPU_RD;
        else if (!fifo_empty)      op = OP_WR;
    end

    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_we_d   = 1'b0;
        ram_din_d  = ram_din_q;
        unique case (op)
            OP_ENG:    ram_addr_d = eng_addr;
            OP_CPU_RD: ram_addr_d = cpu_addr;
            OP_WR: begin
                ram_addr_d = wf_addr;
                ram_din_d  = wf_data;
                ram_we_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (op == OP_WR)
            starve_d = '0;
        else if (fifo_full && starve_q != STARVE_MAX)
            starve_d = starve_q + 1'b1;
    end

    // rd_ret marks the cycle ram_q carries the CPU read data.
    assign eng_valid_d = (op_q == OP_ENG);
    assign rd_ret_d    = (op_q == OP_CPU_RD);

    always_comb begin
        cr_d       = cr_q;
        cpu_dout_d = cpu_dout_q;
        rd_valid_d = 1'b0;
        unique case (cr_q)
            CR_IDLE:
                // Completing read still has cs high; don't restart it.
                if (cpu_cs && !cpu_wr && !rd_valid_q) cr_d = CR_DRAIN;
            CR_DRAIN:
                if (fifo_count == '0 && op_q != OP_WR) cr_d = CR_ISSUE;
            CR_ISSUE:
                if (op == OP_CPU_RD) cr_d = CR_DATA;
            CR_DATA:
                if (rd_ret_q) begin
                    cpu_dout_d = ram_q;
                    rd_valid_d = 1'b1;
                    cr_d       = CR_IDLE;
                end
            default: cr_d = CR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_din_q   <= '0;
            starve_q    <= '0;
            cr_q        <= CR_IDLE;
            cpu_dout_q  <= '0;
            rd_valid_q  <= 1'b0;
            eng_valid_q <= 1'b0;
            rd_ret_q    <= 1'b0;
            op_q        <= OP_NONE;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_din_q   <= ram_din_d;
            starve_q    <= starve_d;
            cr_q        <= cr_d;
            cpu_dout_q  <= cpu_dout_d;
            rd_valid_q  <= rd_valid_d;
            eng_valid_q <= eng_valid_d;
            rd_ret_q    <= rd_ret_d;
            op_q        <= op;
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_we       = ram_we_q;
    assign ram_din      = ram_din_q;
    assign eng_valid    = eng_valid_q;
    assign eng_data     = ram_q;
    assign cpu_dout     = cpu_dout_q;
    assign cpu_rd_valid = rd_valid_q;
    assign cpu_wait     = (cpu_cs & cpu_wr & fifo_full)
                        | (cpu_cs & ~cpu_wr & ~rd_valid_q);

endmodule
